// File: rtl/bus_frame_writer.sv
// rtl/bus_frame_writer.sv - bus-mapped pixel write/readback and full-frame fill engine for frame-buffer port A
module bus_frame_writer #(
    parameter logic [7:0] BASE_ADDR  = 8'hB0,
    parameter int         H_PIXELS   = 160,
    parameter int         V_PIXELS   = 120,
    parameter int         X_WIDTH    = 8,
    parameter int         Y_WIDTH    = 7,
    parameter int         PIXEL_BITS = 1
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic [7:0]                 BUS_ADDR,
    input  logic                       BUS_WE,
    inout  wire  [7:0]                 BUS_DATA,
    output logic [Y_WIDTH+X_WIDTH-1:0] FB_ADDR,
    output logic [PIXEL_BITS-1:0]      FB_DATA_OUT,
    output logic                       FB_WE,
    input  logic [PIXEL_BITS-1:0]      FB_DATA_IN,
    output logic                       BUSY,
    output logic                       FILL_DONE
);

    localparam logic [7:0] OFF_X      = 8'd0;
    localparam logic [7:0] OFF_Y      = 8'd1;
    localparam logic [7:0] OFF_PIXEL  = 8'd2;
    localparam logic [7:0] OFF_CTRL   = 8'd3;
    localparam logic [7:0] OFF_COLOUR = 8'd4;
    localparam logic [7:0] OFF_STATUS = 8'd5;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t                 state;
    logic [X_WIDTH-1:0]     x;
    logic [Y_WIDTH-1:0]     y;
    logic [X_WIDTH-1:0]     fx;
    logic [Y_WIDTH-1:0]     fy;
    logic                   autoinc;
    logic [PIXEL_BITS-1:0]  fill_colour;
    logic [PIXEL_BITS-1:0]  pix_data;
    logic                   fb_we;
    logic                   busy;
    logic                   fill_done;
    logic                   inc_pend;
    logic                   wr_q;

    logic [7:0] off;
    logic       hit;
    logic       wr_req;
    logic       wr_stb;
    logic       pix_stb;
    logic       start_stb;
    logic       in_range;
    logic       x_last;
    logic       y_last;
    logic       fx_last;
    logic       fy_last;
    logic       rd_en;
    logic [7:0] rd_data;

    assign off    = BUS_ADDR - BASE_ADDR;
    assign hit    = (off < 8'd6);
    assign wr_req = BUS_WE & hit;
    // One action per contiguous write assertion, however long it is held.
    assign wr_stb    = wr_req & ~wr_q;
    assign pix_stb   = wr_stb && (off == OFF_PIXEL);
    assign start_stb = wr_stb && (off == OFF_CTRL) && BUS_DATA[1];

    assign in_range = (32'(x) < H_PIXELS) && (32'(y) < V_PIXELS);
    assign x_last   = (32'(x) >= H_PIXELS - 1);
    assign y_last   = (32'(y) >= V_PIXELS - 1);
    assign fx_last  = (32'(fx) == H_PIXELS - 1);
    assign fy_last  = (32'(fy) == V_PIXELS - 1);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= S_IDLE;
            x           <= '0;
            y           <= '0;
            fx          <= '0;
            fy          <= '0;
            autoinc     <= 1'b0;
            fill_colour <= '0;
            pix_data    <= '0;
            fb_we       <= 1'b0;
            busy        <= 1'b0;
            fill_done   <= 1'b0;
            inc_pend    <= 1'b0;
            wr_q        <= 1'b0;
        end else begin
            wr_q     <= wr_req;
            inc_pend <= 1'b0;

            // Advance one cycle after the pixel write so FB_ADDR carries the pre-increment position.
            if (inc_pend) begin
                if (x_last) begin
                    x <= '0;
                    y <= y_last ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    state     <= S_IDLE;
                    fill_done <= 1'b0;
                    fb_we     <= 1'b0;
                    if (pix_stb) begin
                        fb_we    <= in_range;
                        pix_data <= BUS_DATA[PIXEL_BITS-1:0];
                        inc_pend <= autoinc;
                    end
                    if (start_stb && state == S_IDLE) begin
                        state <= S_FILL;
                        busy  <= 1'b1;
                        fb_we <= 1'b1;
                        fx    <= '0;
                        fy    <= '0;
                    end
                end
                S_FILL: begin
                    fb_we <= 1'b1;
                    if (fx_last) begin
                        fx <= '0;
                        if (fy_last) begin
                            state     <= S_DONE;
                            busy      <= 1'b0;
                            fb_we     <= 1'b0;
                            fill_done <= 1'b1;
                        end else begin
                            fy <= fy + 1'b1;
                        end
                    end else begin
                        fx <= fx + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    fb_we <= 1'b0;
                end
            endcase

            if (wr_stb) begin
                case (off)
                    OFF_X:      x           <= BUS_DATA[X_WIDTH-1:0];
                    OFF_Y:      y           <= BUS_DATA[Y_WIDTH-1:0];
                    OFF_CTRL:   autoinc     <= BUS_DATA[0];
                    OFF_COLOUR: fill_colour <= BUS_DATA[PIXEL_BITS-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign FB_ADDR     = busy ? {fy, fx} : {y, x};
    assign FB_DATA_OUT = busy ? fill_colour : pix_data;
    assign FB_WE       = fb_we;
    assign BUSY        = busy;
    assign FILL_DONE   = fill_done;

    always_comb begin
        rd_data = 8'h00;
        rd_en   = 1'b0;
        if (!BUS_WE) begin
            case (off)
                OFF_X: begin
                    rd_en = 1'b1;
                    rd_data[X_WIDTH-1:0] = x;
                end
                OFF_Y: begin
                    rd_en = 1'b1;
                    rd_data[Y_WIDTH-1:0] = y;
                end
                OFF_COLOUR: begin
                    rd_en = 1'b1;
                    rd_data[PIXEL_BITS-1:0] = fill_colour;
                end
                OFF_STATUS: begin
                    rd_en = 1'b1;
                    rd_data[7] = busy;
                    rd_data[PIXEL_BITS-1:0] = FB_DATA_IN;
                end
                default: ;
            endcase
        end
    end

    assign BUS_DATA = rd_en ? rd_data : {8{1'bz}};

endmodule

// File: doc/bus_frame_writer.md
Name: bus_frame_writer

Overview:
- Bus-mapped write/readback engine between the microprocessor data bus and port A of the dual-port frame buffer; the VGA signal generator scans port B.
- Generalises the fixed X/Y/pixel-write register set:
  - configurable base address, resolution and pixel depth
  - optional auto-increment addressing
  - pixel readback
  - hardware full-frame fill engine with busy status and completion pulse

Parameters:
BASE_ADDR  8'hB0  bus address of register 0; block decodes BASE_ADDR..BASE_ADDR+5
H_PIXELS  160  visible columns
V_PIXELS  120  visible rows
X_WIDTH  8  X coordinate width
Y_WIDTH  7  Y coordinate width
PIXEL_BITS  1  bits per pixel, legal range 1..7

Ports:
CLK  in  1  system clock
Reset  in  1  synchronous, active-high reset
BUS_ADDR  in  8  processor data-bus address
BUS_WE  in  1  bus write enable; 0 = read
BUS_DATA  inout  8  bidirectional data bus; driven only on a decoded read, else high-Z
FB_ADDR  out  Y_WIDTH+X_WIDTH  frame-buffer port-A address {Y,X}
FB_DATA_OUT  out  PIXEL_BITS  frame-buffer port-A write data
FB_WE  out  1  frame-buffer port-A write enable
FB_DATA_IN  in  PIXEL_BITS  frame-buffer port-A read data, 1-cycle latency from FB_ADDR
BUSY  out  1  fill engine active
FILL_DONE  out  1  one-cycle pulse when a fill completes

Behaviour:

Register map (offset from BASE_ADDR):
- 0: X, read/write
- 1: Y, read/write, low Y_WIDTH bits
- 2: PIXEL, write-only; triggers a pixel write
- 3: CTRL, write-only
  - bit0 AUTOINC
  - bit1 FILL_START, self-clearing
- 4: FILL_COLOUR, read/write, low PIXEL_BITS bits
- 5: STATUS, read-only
  - bit7 = BUSY
  - bits[PIXEL_BITS-1:0] = FB_DATA_IN
  - other bits 0

Bus write decode:
- A write is a rising edge of (BUS_WE & address hit), detected against a registered copy.
- Exactly one action per contiguous assertion, however many cycles it is held.

Bus read:
- BUS_DATA is driven combinationally while BUS_WE=0 and BUS_ADDR is readable offset 0, 1, 4 or 5; otherwise high-Z.
- Unused upper bits read 0.

Reset values:
- X=0, Y=0, AUTOINC=0, FILL_COLOUR=0
- FB_WE=0, FB_DATA_OUT=0
- BUSY=0, FILL_DONE=0
- FSM in IDLE
- Reset asserted mid-fill aborts the fill immediately: no FILL_DONE pulse, FB_WE=0 next cycle.

Pixel write:
- Write strobe to offset 2 sampled at edge n.
- During cycle n+1: FB_WE=1, FB_ADDR={Y,X} (pre-increment values), FB_DATA_OUT=BUS_DATA[PIXEL_BITS-1:0] captured at edge n.
- If X>=H_PIXELS or Y>=V_PIXELS the write is suppressed (FB_WE stays 0); auto-increment still applies.

Auto-increment (AUTOINC=1), applied at edge n+1:
- X+1 normally.
- If X>=H_PIXELS-1: X=0, Y+1.
- If additionally Y>=V_PIXELS-1: X=0, Y=0 (wrap to origin).
- A simultaneous X/Y register write cannot occur: the bus is single-access.

Readback:
- FB_ADDR idles at {Y,X}.
- STATUS read returns the pixel at the current X,Y once one cycle has passed since the last X/Y update.

Fill FSM, states IDLE, FILL, DONE:
- IDLE -> FILL: on a CTRL write with bit1=1.
  - Internal counters fx=0, fy=0; BUSY=1 from the next cycle.
- FILL: each cycle FB_WE=1, FB_ADDR={fy,fx}, FB_DATA_OUT=FILL_COLOUR.
  - fx/fy advance row-major.
  - After writing (H_PIXELS-1, V_PIXELS-1), go to DONE.
  - A fill takes exactly H_PIXELS*V_PIXELS write cycles.
- DONE: one cycle; FILL_DONE=1, FB_WE=0, BUSY=0. Then IDLE.
- While BUSY:
  - PIXEL writes are dropped (no FB write, no auto-increment).
  - FILL_START is ignored.
  - X, Y, CTRL.AUTOINC and FILL_COLOUR writes still update their registers.
  - A FILL_COLOUR change takes effect on the following fill cycle.
  - FB_ADDR is owned by the fill counters; STATUS pixel bits are undefined.

Test Plan:
- Reset, then write X=5, Y=7, PIXEL=1 -> one cycle later: FB_WE high for exactly 1 cycle, FB_ADDR={7'd7,8'd5}, FB_DATA_OUT=1; X and Y unchanged.
- AUTOINC=1, X=159, Y=3, PIXEL write held on the bus for 4 cycles -> single FB write at (159,3); X=0, Y=4 afterwards. Repeat from (159,119) -> wraps to (0,0).
- Write X=200, PIXEL write -> no FB_WE; read X -> 200 returned on BUS_DATA. Read offset 2 -> BUS_DATA high-Z.
- FILL_COLOUR=1, CTRL=0x02 -> BUSY high next cycle; 19200 consecutive FB_WE cycles covering addresses (0,0)..(159,119) in order; FILL_DONE pulse 1 cycle; BUSY low. A PIXEL write issued mid-fill is absent from the FB write trace.
- Assert Reset 500 cycles into a fill -> FB_WE low on the following cycle, BUSY=0, no FILL_DONE. A new fill started afterwards begins at (0,0).
- Frame buffer model returns the stored pixel; write (10,10)=1, then read STATUS -> BUS_DATA bit0=1, bit7=0.
